// File: rtl/count_window_ctrl.sv
// Measurement-window sequencer for a bank of NCNT counters.
// Each window clears the counters, enables them for len cycles, waits one
// drain cycle for the registered overflow flags, then strobes capture.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               run request, sampled only while idle
//   len, num_win        window length and window count, latched on accept
//   abort_on_ovf        end the run at the first overflow, latched on accept
//   cnt_ovf             overflow flags from the counter bank
//   cnt_clr, cnt_en     clear / enable to the counter bank
//   capture, win_idx    result strobe and index of the current window
//   busy, done          run in progress / one-cycle end-of-run pulse
//   ovf_sticky          per-channel overflow seen during the run
//   ovf_abort           run ended early because of an overflow
module count_window_ctrl #(
    parameter int unsigned NCNT  = 4,
    parameter int unsigned LEN_W = 16,
    parameter int unsigned WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [WIN_W-1:0] num_win,
    input  logic             abort_on_ovf,
    input  logic [NCNT-1:0]  cnt_ovf,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic             capture,
    output logic [WIN_W-1:0] win_idx,
    output logic             busy,
    output logic             done,
    output logic [NCNT-1:0]  ovf_sticky,
    output logic             ovf_abort
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_CAPT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cyc_q;
    logic [WIN_W-1:0] num_win_q;
    logic             abort_q;

    logic accept_c;
    logic abort_hit_c;
    logic last_win_c;

    logic cnt_clr_d;
    logic cnt_en_d;
    logic capture_d;
    logic busy_d;
    logic done_d;

    assign accept_c    = (state == S_IDLE) && start;
    assign abort_hit_c = abort_q && (|cnt_ovf) && ((state == S_RUN) || (state == S_DRAIN));
    // An aborted run ends after the capture of the window it was in.
    assign last_win_c  = ovf_abort || (win_idx == (num_win_q - WIN_W'(1)));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if ((len == '0) || (num_win == '0)) begin
                        next_state = S_DONE;
                    end else begin
                        next_state = S_CLEAR;
                    end
                end
            end
            S_CLEAR: next_state = S_RUN;
            S_RUN: begin
                if (abort_hit_c) begin
                    next_state = S_CAPT;
                end else if (cyc_q == LEN_W'(1)) begin
                    next_state = S_DRAIN;
                end
            end
            S_DRAIN: next_state = S_CAPT;
            S_CAPT:  next_state = last_win_c ? S_DONE : S_CLEAR;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state; registered below.
    always_comb begin
        cnt_clr_d = 1'b0;
        cnt_en_d  = 1'b0;
        capture_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (next_state)
            S_CLEAR: begin cnt_clr_d = 1'b1; busy_d = 1'b1; end
            S_RUN:   begin cnt_en_d  = 1'b1; busy_d = 1'b1; end
            S_DRAIN: begin busy_d    = 1'b1; end
            S_CAPT:  begin capture_d = 1'b1; busy_d = 1'b1; end
            S_DONE:  begin done_d    = 1'b1; busy_d = 1'b1; end
            default: begin end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_clr <= 1'b0;
            cnt_en  <= 1'b0;
            capture <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            cnt_clr <= cnt_clr_d;
            cnt_en  <= cnt_en_d;
            capture <= capture_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Run configuration, cycle down-counter, window index and overflow tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q      <= '0;
            num_win_q  <= '0;
            abort_q    <= 1'b0;
            cyc_q      <= '0;
            win_idx    <= '0;
            ovf_sticky <= '0;
            ovf_abort  <= 1'b0;
        end else begin
            if (accept_c) begin
                len_q      <= len;
                num_win_q  <= num_win;
                abort_q    <= abort_on_ovf;
                win_idx    <= '0;
                ovf_sticky <= '0;
                ovf_abort  <= 1'b0;
            end
            if (state == S_CLEAR) begin
                cyc_q <= len_q;
            end else if (state == S_RUN) begin
                cyc_q <= cyc_q - LEN_W'(1);
            end
            if ((state == S_RUN) || (state == S_DRAIN) || (state == S_CAPT)) begin
                ovf_sticky <= ovf_sticky | cnt_ovf;
            end
            if (abort_hit_c) begin
                ovf_abort <= 1'b1;
            end
            if ((state == S_CAPT) && !last_win_c) begin
                win_idx <= win_idx + WIN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_count_window_ctrl.sv
// Randomised and directed bench for count_window_ctrl against a timeline model.
module tb_count_window_ctrl;

    localparam int unsigned NCNT  = 4;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned WIN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [WIN_W-1:0] num_win;
    logic             abort_on_ovf;
    logic [NCNT-1:0]  cnt_ovf;
    logic             cnt_clr;
    logic             cnt_en;
    logic             capture;
    logic [WIN_W-1:0] win_idx;
    logic             busy;
    logic             done;
    logic [NCNT-1:0]  ovf_sticky;
    logic             ovf_abort;

    int checks = 0;
    int errors = 0;

    // Observed pulse counts, written only by the compare process.
    int n_clr  = 0;
    int n_en   = 0;
    int n_cap  = 0;
    int n_done = 0;

    // Model state: a run is a timeline t = 1, 2, ... counted from start accept.
    bit              m_busy   = 1'b0;
    int              m_t      = 0;
    int              m_l      = 0;
    int              m_n      = 0;
    bit              m_ab     = 1'b0;
    int              m_cap_t  = -1;
    logic [NCNT-1:0] m_sticky = '0;
    bit              m_ovfab  = 1'b0;
    logic [WIN_W-1:0] m_win   = '0;
    bit e_clr  = 1'b0;
    bit e_en   = 1'b0;
    bit e_cap  = 1'b0;
    bit e_done = 1'b0;

    count_window_ctrl #(.NCNT(NCNT), .LEN_W(LEN_W), .WIN_W(WIN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len          (len),
        .num_win      (num_win),
        .abort_on_ovf (abort_on_ovf),
        .cnt_ovf      (cnt_ovf),
        .cnt_clr      (cnt_clr),
        .cnt_en       (cnt_en),
        .capture      (capture),
        .win_idx      (win_idx),
        .busy         (busy),
        .done         (done),
        .ovf_sticky   (ovf_sticky),
        .ovf_abort    (ovf_abort)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Phase of timeline cycle t: 0 none, 1 clear, 2 enable, 3 drain, 4 capture, 5 done.
    function automatic int phase(input int t);
        int p;
        int o;
        p = m_l + 3;
        if ((m_l == 0) || (m_n == 0)) return (t == 1) ? 5 : 0;
        if (m_cap_t >= 0) begin
            if (t == m_cap_t) return 4;
            if (t == m_cap_t + 1) return 5;
            if (t > m_cap_t + 1) return 0;
        end
        if (t == m_n * p + 1) return 5;
        if (t > m_n * p + 1) return 0;
        o = (t - 1) % p;
        if (o == 0) return 1;
        if (o <= m_l) return 2;
        if (o == m_l + 1) return 3;
        return 4;
    endfunction

    // Reference model, advanced on every active edge.
    initial forever begin
        int p;
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_busy = 1'b0; m_t = 0; m_l = 0; m_n = 0; m_ab = 1'b0; m_cap_t = -1;
            m_sticky = '0; m_ovfab = 1'b0; m_win = '0;
            e_clr = 1'b0; e_en = 1'b0; e_cap = 1'b0; e_done = 1'b0;
        end else begin
            if (m_busy) begin
                p = phase(m_t);
                if ((p == 2) || (p == 3) || (p == 4)) m_sticky = m_sticky | cnt_ovf;
                if (m_ab && ((p == 2) || (p == 3)) && (cnt_ovf != '0) && (m_cap_t < 0)) begin
                    m_cap_t = m_t + 1;
                    m_ovfab = 1'b1;
                end
                if (p == 5) m_busy = 1'b0;
                else m_t++;
            end else if (start) begin
                m_l = int'(len); m_n = int'(num_win); m_ab = abort_on_ovf;
                m_t = 1; m_busy = 1'b1; m_cap_t = -1;
                m_sticky = '0; m_ovfab = 1'b0; m_win = '0;
            end
            p = m_busy ? phase(m_t) : 0;
            e_clr  = (p == 1);
            e_en   = (p == 2);
            e_cap  = (p == 4);
            e_done = (p == 5);
            if ((p >= 1) && (p <= 4)) m_win = WIN_W'((m_t - 1) / (m_l + 3));
        end
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        chk("cnt_clr",    32'(cnt_clr),    32'(e_clr));
        chk("cnt_en",     32'(cnt_en),     32'(e_en));
        chk("capture",    32'(capture),    32'(e_cap));
        chk("done",       32'(done),       32'(e_done));
        chk("busy",       32'(busy),       32'(m_busy));
        chk("win_idx",    32'(win_idx),    32'(m_win));
        chk("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
        chk("ovf_abort",  32'(ovf_abort),  32'(m_ovfab));
        if (cnt_clr) n_clr++;
        if (cnt_en)  n_en++;
        if (capture) n_cap++;
        if (done)    n_done++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench in timeline cycle 1 of the accepted run.
    task automatic run_start(input int l, input int n, input bit a);
        step();
        len = LEN_W'(l); num_win = WIN_W'(n); abort_on_ovf = a; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_idle_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        int c0, e0, k0, d0;
        rst = 1'b1; start = 1'b0; len = '0; num_win = '0; abort_on_ovf = 1'b0; cnt_ovf = '0;
        #1 rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();

        // Single window, len 5: literal timeline.
        run_start(5, 1, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk("t1_clr",  32'(cnt_clr), 32'(c == 1));
            chk("t1_en",   32'(cnt_en),  32'((c >= 2) && (c <= 6)));
            chk("t1_cap",  32'(capture), 32'(c == 8));
            chk("t1_done", 32'(done),    32'(c == 9));
            chk("t1_busy", 32'(busy),    32'(c <= 9));
            chk("t1_win",  32'(win_idx), 32'd0);
        end

        // Three windows of len 3; config changed after accept must not matter.
        c0 = n_clr; k0 = n_cap; d0 = n_done;
        run_start(3, 3, 1'b0);
        len = 16'd9; num_win = 8'd1;
        wait_idle(40);
        chk("t2_caps",   32'(n_cap - k0),  32'd3);
        chk("t2_clrs",   32'(n_clr - c0),  32'd3);
        chk("t2_dones",  32'(n_done - d0), 32'd1);
        chk("t2_sticky", 32'(ovf_sticky),  32'd0);
        chk("t2_win",    32'(win_idx),     32'd2);

        // Zero length: immediate done, counters untouched.
        c0 = n_clr; e0 = n_en; k0 = n_cap; d0 = n_done;
        run_start(0, 4, 1'b0);
        @(negedge clk);
        chk("t3_done", 32'(done), 32'd1);
        wait_idle(5);
        chk("t3_clrs",  32'(n_clr - c0),  32'd0);
        chk("t3_ens",   32'(n_en - e0),   32'd0);
        chk("t3_caps",  32'(n_cap - k0),  32'd0);
        chk("t3_dones", 32'(n_done - d0), 32'd1);

        // Overflow abort in RUN cycle 7 of window 0.
        k0 = n_cap; d0 = n_done;
        run_start(20, 2, 1'b1);
        repeat (7) step();
        cnt_ovf = 4'b0010;
        step();
        cnt_ovf = '0;
        @(negedge clk);
        chk("t4_en_drop", 32'(cnt_en),  32'd0);
        chk("t4_cap",     32'(capture), 32'd1);
        chk("t4_win",     32'(win_idx), 32'd0);
        wait_idle(50);
        chk("t4_abort",  32'(ovf_abort),  32'd1);
        chk("t4_sticky", 32'(ovf_sticky), 32'h2);
        chk("t4_caps",   32'(n_cap - k0),  32'd1);
        chk("t4_dones",  32'(n_done - d0), 32'd1);

        // Same overflow without abort: both windows complete.
        k0 = n_cap;
        run_start(20, 2, 1'b0);
        repeat (7) step();
        cnt_ovf = 4'b0010;
        step();
        cnt_ovf = '0;
        wait_idle(100);
        chk("t5_abort",  32'(ovf_abort),  32'd0);
        chk("t5_sticky", 32'(ovf_sticky), 32'h2);
        chk("t5_caps",   32'(n_cap - k0), 32'd2);
        run_start(2, 1, 1'b0);
        @(negedge clk);
        chk("t5_sticky_clr", 32'(ovf_sticky), 32'd0);
        wait_idle(20);

        // Asynchronous reset mid-run, then a normal run ignoring mid-run starts.
        d0 = n_done;
        run_start(10, 1, 1'b0);
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("t6_en_async",   32'(cnt_en),  32'd0);
        chk("t6_busy_async", 32'(busy),    32'd0);
        chk("t6_clr_async",  32'(cnt_clr), 32'd0);
        step();
        step();
        rst = 1'b1;
        chk("t6_no_done", 32'(n_done - d0), 32'd0);
        k0 = n_cap; d0 = n_done;
        run_start(2, 2, 1'b0);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle(30);
        chk("t6_caps",  32'(n_cap - k0),  32'd2);
        chk("t6_dones", 32'(n_done - d0), 32'd1);

        // Maximum window count.
        k0 = n_cap;
        run_start(1, 255, 1'b0);
        wait_idle(1100);
        chk("tmax_caps", 32'(n_cap - k0), 32'd255);
        chk("tmax_win",  32'(win_idx),    32'd254);

        // Random traffic, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step();
            start        = ($urandom_range(0, 3) == 0);
            len          = LEN_W'($urandom_range(0, 6));
            num_win      = WIN_W'($urandom_range(0, 4));
            abort_on_ovf = 1'($urandom_range(0, 1));
            cnt_ovf      = ($urandom_range(0, 5) == 0) ? NCNT'($urandom) : '0;
            rst          = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
        end
        step();
        start = 1'b0; cnt_ovf = '0; rst = 1'b1;
        wait_idle(200);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
